mannix_mem_bank_sched: RTL
==========================

# mannix_mem_bank_sched

Parametrised multi-client, multi-bank request scheduler for the Mannix memory farm. It accepts burst read and write transactions from `NUM_CLIENTS` engine clients (FCC, CNN, pool, SW), splits each burst into line accesses, and interleaves the lines across `NUM_BANKS` SRAM banks. A round-robin arbiter per bank, with an optional strict-priority client, drives the bank ports. It replaces the fixed 16-slot request controller.

## Interface
- `NUM_CLIENTS`, 8, number of clients (≥2)
- `NUM_BANKS`, 16, number of SRAM banks (power of 2)
- `WORD_WIDTH`, 8, bits per word
- `NUM_WORDS_IN_LINE`, 32, words per line; LB = line bytes = NUM_WORDS_IN_LINE*WORD_WIDTH/8 (power of 2); LW = LB*8
- `ADDR_WIDTH`, 19, client byte-address width
- `SIZE_WIDTH`, 20, transfer-size width in bytes
- Derived: BA = ADDR_WIDTH − log2(LB) − log2(NUM_BANKS), the bank-local line-address width
- `clk` in 1: clock
- `rst_n` in 1: asynchronous active-low reset
- `client_req` in [NUM_CLIENTS]: transaction request, held high until `client_done`
- `client_we` in [NUM_CLIENTS]: 1 = write, 0 = read
- `client_addr` in [NUM_CLIENTS][ADDR_WIDTH]: start byte address; low log2(LB) bits are ignored (line aligned)
- `client_size` in [NUM_CLIENTS][SIZE_WIDTH]: transfer size in bytes
- `client_wdata` in [NUM_CLIENTS][LW]: write line; it is consumed in the cycle `client_ack` is high
- `client_ack` out [NUM_CLIENTS]: line issued to a bank (grant pulse)
- `client_rvalid` out [NUM_CLIENTS]: read line valid
- `client_rdata` out [NUM_CLIENTS][LW]: read line
- `client_rlast` out [NUM_CLIENTS]: last read line of the burst
- `client_done` out [NUM_CLIENTS]: one-cycle transaction-complete pulse
- `hi_prio_en` in 1: enables strict priority
- `hi_prio_client` in [log2 NUM_CLIENTS]: index of the strict-priority client
- `bank_cs` out [NUM_BANKS]: bank access strobe
- `bank_we` out [NUM_BANKS]: bank write enable
- `bank_addr` out [NUM_BANKS][BA]: bank-local line address
- `bank_wdata` out [NUM_BANKS][LW]: bank write data
- `bank_wmask` out [NUM_BANKS][LB]: byte write mask
- `bank_rdata` in [NUM_BANKS][LW]: read data, valid 1 cycle after `bank_cs & ~bank_we`

## Operation
- Per-client FSM with states IDLE, BUSY, DRAIN.
  - IDLE & `client_req`:
    - Capture `we`, the line address L = addr >> log2(LB), and the line count N = ceil(size/LB).
    - Capture the tail T = size mod LB.
    - If N = 0, go to DRAIN without any bank access. Otherwise go to BUSY.
  - BUSY: request bank `L[log2 NUM_BANKS−1:0]` at bank address `L >> log2 NUM_BANKS`.
    - On grant: `client_ack` = 1; L increments; remaining count decrements.
    - When the remaining count reaches 0: a write goes to IDLE and pulses `client_done` together with its last `client_ack`; a read goes to DRAIN.
  - DRAIN: lasts one cycle, then IDLE. A read pulses `client_rvalid`, `client_rlast` and `client_done` in this cycle. An N = 0 transaction pulses `client_done` alone.
- L increments modulo 2^(ADDR_WIDTH−log2 LB), so bank addresses wrap to 0.
- Per-bank arbitration:
  - Requesters are the BUSY clients targeting that bank.
  - If `hi_prio_en` and `hi_prio_client` is requesting that bank, that client wins.
  - Otherwise round-robin: search from pointer P upward; the winner is w and P becomes (w+1) mod NUM_CLIENTS.
  - A strict-priority win does not move P.
- The bank ports are combinational from the winner: `bank_cs` = 1, `bank_we` = client `we`, plus addr and wdata.
- `bank_wmask` is all ones, except on the final line of a write with T ≠ 0, where only bytes [T−1:0] are set. Reads drive the mask to 0.
- Read return: a registered (bank, client, last) record per bank, one cycle later.
  - Drives `client_rvalid` and `client_rdata` = `bank_rdata[bank]`.
  - `client_rlast` is set on the final line.
  - A client is granted at most one bank per cycle, so return data never collides.
- `client_req` is sampled only in IDLE. Deasserting it mid-transaction has no effect.

## Timing
- All outputs are 0 while reset is asserted. Reset mid-transaction aborts every FSM to IDLE, clears P to 0, discards pending read records, and produces no `done`.
- The transaction is accepted at cycle t. The first bank request is at t+1, so the earliest `client_ack`/`bank_cs` is at t+1.
- Read data for a grant at cycle g appears at g+1. Read `done` comes one cycle after the final grant. Write `done` comes in the final grant cycle.
- Throughput is one line per client per cycle when uncontended. Different banks serve different clients in parallel in the same cycle.
- After `done`, a client whose `client_req` is still high starts a new transaction in the next cycle (IDLE acceptance).
- Round-robin fairness: with k clients contending on one bank, each client is granted within k cycles.
  - With `hi_prio_en` held, the priority client can starve the others. This is intended.

## Test plan
- **Single read:** client 0 reads addr 0x0040, size 96 (LB=32, 16 banks).
  - ack at t+1..t+3 on banks 2, 3, 4 with bank addr 0.
  - rvalid at t+2..t+4; rlast and done at t+4.
- **Partial write:** client 3 writes addr 0x1E0, size 40.
  - 2 lines on banks 15 and 0.
  - Bank 0 gets bank addr 1 (line 16 wraps to bank 0) and wmask 0x000000FF.
  - done with the second ack.
- **Contention:** clients 0, 1 and 2 all start at addr 0, size 32 each, same cycle.
  - Bank 0 grants 0, 1, 2 in consecutive cycles; P ends at 3.
  - With `hi_prio_en` and `hi_prio_client` = 2, the grant order is 2, 0, 1.
- **Parallel banks:** client 0 at addr 0 and client 1 at addr 0x20, each size 64.
  - Both acked every cycle with no stall; 4 bank accesses in 2 cycles.
- **Edges:** size 0 gives done at t+1 with no `bank_cs`. A burst crossing the top address wraps L to 0.
- **Reset mid-burst:** assert `rst_n` = 0 during the 2nd line of a 4-line read.
  - All outputs 0; no done or rvalid after release.
  - A fresh request is serviced normally.

Source files
------------

// File: rtl/mannix_mem_bank_sched.sv
// Purpose : splits client burst reads/writes into line accesses and schedules them onto interleaved SRAM banks.
// Latency : first bank access one cycle after acceptance; read data one cycle after grant; one line/client/cycle.
// Backpress: a client waits in BUSY until its bank arbiter grants it (client_ack); banks never stall the scheduler.
//
// Ports (flattened per client / per bank, index i occupies slice [i*W +: W]):
//   clk, rst_n                 clock, async active-low reset
//   client_req/we/addr/size    transaction request (held until client_done), direction, byte address, byte size
//   client_wdata               write line, consumed in the client_ack cycle
//   client_ack/done            per-line grant pulse, one-cycle transaction-complete pulse
//   client_rvalid/rdata/rlast  read return
//   hi_prio_en/hi_prio_client  optional strict-priority client
//   bank_cs/we/addr/wdata/wmask  bank access port (combinational from the winning client)
//   bank_rdata                 bank read data, valid one cycle after a read access
module mannix_mem_bank_sched #(
  parameter int NUM_CLIENTS       = 8,
  parameter int NUM_BANKS         = 16,
  parameter int WORD_WIDTH        = 8,
  parameter int NUM_WORDS_IN_LINE = 32,
  parameter int ADDR_WIDTH        = 19,
  parameter int SIZE_WIDTH        = 20,
  localparam int LB  = NUM_WORDS_IN_LINE * WORD_WIDTH / 8,
  localparam int LW  = LB * 8,
  localparam int LBW = $clog2(LB),
  localparam int NBW = $clog2(NUM_BANKS),
  localparam int BA  = ADDR_WIDTH - LBW - NBW,
  localparam int CW  = $clog2(NUM_CLIENTS)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_CLIENTS-1:0]        client_req,
  input  logic [NUM_CLIENTS-1:0]        client_we,
  input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] client_addr,
  input  logic [NUM_CLIENTS*SIZE_WIDTH-1:0] client_size,
  input  logic [NUM_CLIENTS*LW-1:0]     client_wdata,
  output logic [NUM_CLIENTS-1:0]        client_ack,
  output logic [NUM_CLIENTS-1:0]        client_rvalid,
  output logic [NUM_CLIENTS*LW-1:0]     client_rdata,
  output logic [NUM_CLIENTS-1:0]        client_rlast,
  output logic [NUM_CLIENTS-1:0]        client_done,
  input  logic                          hi_prio_en,
  input  logic [CW-1:0]                 hi_prio_client,
  output logic [NUM_BANKS-1:0]          bank_cs,
  output logic [NUM_BANKS-1:0]          bank_we,
  output logic [NUM_BANKS*BA-1:0]       bank_addr,
  output logic [NUM_BANKS*LW-1:0]       bank_wdata,
  output logic [NUM_BANKS*LB-1:0]       bank_wmask,
  input  logic [NUM_BANKS*LW-1:0]       bank_rdata
);

  localparam int LA = ADDR_WIDTH - LBW;      // line address width
  localparam int NW = SIZE_WIDTH - LBW + 1;  // line count width (ceil can carry)

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DRAIN} state_t;

  // per-client transaction state
  state_t                 st_q   [NUM_CLIENTS];
  state_t                 st_d   [NUM_CLIENTS];
  logic [NUM_CLIENTS-1:0] we_q, we_d;
  logic [LA-1:0]          line_q [NUM_CLIENTS];
  logic [LA-1:0]          line_d [NUM_CLIENTS];
  logic [NW-1:0]          rem_q  [NUM_CLIENTS];
  logic [NW-1:0]          rem_d  [NUM_CLIENTS];
  logic [LBW-1:0]         tail_q [NUM_CLIENTS];
  logic [LBW-1:0]         tail_d [NUM_CLIENTS];
  logic [NUM_CLIENTS-1:0] cl_gnt;
  logic [NUM_CLIENTS-1:0] done_w;

  // per-bank arbitration
  logic [NUM_CLIENTS-1:0] bank_req [NUM_BANKS];
  logic [NUM_CLIENTS-1:0] bank_gnt [NUM_BANKS];
  logic [CW-1:0]          win      [NUM_BANKS];
  logic [NUM_BANKS-1:0]   win_vld;
  logic [CW-1:0]          ptr_q    [NUM_BANKS];
  logic [CW-1:0]          ptr_d    [NUM_BANKS];

  // per-bank read return record
  logic [NUM_BANKS-1:0]   rd_vld_q;
  logic [NUM_BANKS-1:0]   rd_last_q;
  logic [CW-1:0]          rd_cl_q  [NUM_BANKS];

  // low address bits are line offsets and deliberately ignored
  logic addr_lsb_unused;
  always_comb begin
    addr_lsb_unused = 1'b0;
    for (int c = 0; c < NUM_CLIENTS; c++) begin
      addr_lsb_unused = addr_lsb_unused ^ (^client_addr[c*ADDR_WIDTH +: LBW]);
    end
  end

  // ---------------------------------------------------------------------------
  // Client FSM next state
  // ---------------------------------------------------------------------------
  always_comb begin
    logic [NW-1:0] nlines;
    nlines = '0;
    done_w = '0;
    we_d   = we_q;
    for (int c = 0; c < NUM_CLIENTS; c++) begin
      st_d[c]   = st_q[c];
      line_d[c] = line_q[c];
      rem_d[c]  = rem_q[c];
      tail_d[c] = tail_q[c];
      case (st_q[c])
        ST_IDLE: begin
          if (client_req[c]) begin
            // ceil(size / LB): whole lines plus one for any partial tail
            nlines = {1'b0, client_size[c*SIZE_WIDTH+LBW +: SIZE_WIDTH-LBW]}
                   + NW'(|client_size[c*SIZE_WIDTH +: LBW]);
            we_d[c]   = client_we[c];
            line_d[c] = client_addr[c*ADDR_WIDTH+LBW +: LA];
            rem_d[c]  = nlines;
            tail_d[c] = client_size[c*SIZE_WIDTH +: LBW];
            st_d[c]   = (nlines == '0) ? ST_DRAIN : ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (cl_gnt[c]) begin
            line_d[c] = line_q[c] + LA'(1);  // wraps at the top of the address space
            rem_d[c]  = rem_q[c] - NW'(1);
            if (rem_q[c] == NW'(1)) begin
              if (we_q[c]) begin
                st_d[c]   = ST_IDLE;
                done_w[c] = 1'b1;       // write completes with its last ack
              end else begin
                st_d[c]   = ST_DRAIN;   // wait for the last read line to return
              end
            end
          end
        end
        ST_DRAIN: begin
          st_d[c]   = ST_IDLE;
          done_w[c] = 1'b1;
        end
        default: st_d[c] = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q <= '0;
      for (int c = 0; c < NUM_CLIENTS; c++) begin
        st_q[c]   <= ST_IDLE;
        line_q[c] <= '0;
        rem_q[c]  <= '0;
        tail_q[c] <= '0;
      end
    end else begin
      we_q <= we_d;
      for (int c = 0; c < NUM_CLIENTS; c++) begin
        st_q[c]   <= st_d[c];
        line_q[c] <= line_d[c];
        rem_q[c]  <= rem_d[c];
        tail_q[c] <= tail_d[c];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Per-bank arbitration: strict priority first, else round-robin from ptr.
  // A priority win leaves the pointer untouched.
  // ---------------------------------------------------------------------------
  always_comb begin
    int            idx;
    logic [CW-1:0] sel;
    logic          found;
    idx    = 0;
    sel    = '0;
    found  = 1'b0;
    cl_gnt = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      bank_req[b] = '0;
      for (int c = 0; c < NUM_CLIENTS; c++) begin
        bank_req[b][c] = (st_q[c] == ST_BUSY) && (line_q[c][NBW-1:0] == NBW'(b));
      end
      bank_gnt[b] = '0;
      win[b]      = '0;
      ptr_d[b]    = ptr_q[b];
      found       = 1'b0;
      if (hi_prio_en && (int'(hi_prio_client) < NUM_CLIENTS) && bank_req[b][hi_prio_client]) begin
        found  = 1'b1;
        win[b] = hi_prio_client;
      end else begin
        for (int i = 0; i < NUM_CLIENTS; i++) begin
          idx = int'(ptr_q[b]) + i;
          if (idx >= NUM_CLIENTS) idx = idx - NUM_CLIENTS;
          sel = CW'(idx);
          if (!found && bank_req[b][sel]) begin
            found    = 1'b1;
            win[b]   = sel;
            ptr_d[b] = (idx == NUM_CLIENTS - 1) ? '0 : CW'(idx + 1);
          end
        end
      end
      win_vld[b] = found;
      if (found) bank_gnt[b][win[b]] = 1'b1;
      // a client targets exactly one bank, so OR-ing banks cannot double-grant
      cl_gnt = cl_gnt | bank_gnt[b];
    end
  end

  // ---------------------------------------------------------------------------
  // Bank port drive, combinational from the winner
  // ---------------------------------------------------------------------------
  always_comb begin
    logic [CW-1:0] w;
    w          = '0;
    bank_cs    = '0;
    bank_we    = '0;
    bank_addr  = '0;
    bank_wdata = '0;
    bank_wmask = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      w = win[b];
      if (win_vld[b]) begin
        bank_cs[b]             = 1'b1;
        bank_we[b]             = we_q[w];
        bank_addr[b*BA +: BA]  = line_q[w][LA-1:NBW];
        if (we_q[w]) begin
          bank_wdata[b*LW +: LW] = client_wdata[int'(w)*LW +: LW];
          // only the final line of a write with a partial tail is masked
          if ((rem_q[w] == NW'(1)) && (tail_q[w] != '0))
            bank_wmask[b*LB +: LB] = (LB'(1) << tail_q[w]) - LB'(1);
          else
            bank_wmask[b*LB +: LB] = '1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read return: remember who read which bank, route data back next cycle
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld_q  <= '0;
      rd_last_q <= '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
        rd_cl_q[b] <= '0;
        ptr_q[b]   <= '0;
      end
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        rd_vld_q[b]  <= win_vld[b] & ~we_q[win[b]];
        rd_last_q[b] <= (rem_q[win[b]] == NW'(1));
        rd_cl_q[b]   <= win[b];
        ptr_q[b]     <= ptr_d[b];
      end
    end
  end

  always_comb begin
    client_rvalid = '0;
    client_rdata  = '0;
    client_rlast  = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (rd_vld_q[b]) begin
        client_rvalid[rd_cl_q[b]]               = 1'b1;
        client_rdata[int'(rd_cl_q[b])*LW +: LW] = bank_rdata[b*LW +: LW];
        client_rlast[rd_cl_q[b]]                = rd_last_q[b];
      end
    end
  end

  assign client_ack  = cl_gnt;
  assign client_done = done_w;

endmodule
